// File: rtl/fifo_burst_reader_if.sv
// Stream and FIFO read-port bundle for fifo_burst_reader.
// Signal names are from the reader's side: i_* flow into the reader, o_* flow out of it.
//   i_FIFO_COUNT  FIFO occupancy
//   i_FIFO_DATA   FIFO read data, valid the cycle after o_FIFO_RD_EN
//   o_FIFO_RD_EN  FIFO read strobe
//   o_TDATA/o_TVALID/o_TLAST  stream payload, valid and end-of-burst marker
//   i_TREADY      stream ready from the consumer
interface fifo_burst_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 6
);
  logic [CW-1:0]    i_FIFO_COUNT;
  logic [WIDTH-1:0] i_FIFO_DATA;
  logic             o_FIFO_RD_EN;
  logic [WIDTH-1:0] o_TDATA;
  logic             o_TVALID;
  logic             i_TREADY;
  logic             o_TLAST;

  // Reader side
  modport master (
    input  i_FIFO_COUNT, i_FIFO_DATA, i_TREADY,
    output o_FIFO_RD_EN, o_TDATA, o_TVALID, o_TLAST
  );

  // FIFO plus stream-consumer side
  modport slave (
    output i_FIFO_COUNT, i_FIFO_DATA, i_TREADY,
    input  o_FIFO_RD_EN, o_TDATA, o_TVALID, o_TLAST
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side master for a synchronous FIFO with 1-cycle read latency. Drains the FIFO in bursts
// of BURST_LEN words (or a shorter flush burst after FLUSH_TIMEOUT idle cycles with data
// waiting) and presents them as a valid/ready stream, o_TLAST marking each burst's last word.
// Ports:
//   i_CLK    clock, rising edge
//   i_RESET  synchronous reset, active-high
//   bus      fifo_burst_reader_if.master: FIFO count/data/rd_en and TDATA/TVALID/TREADY/TLAST
//   o_BUSY   burst in progress
//   o_FLUSH  1-cycle pulse in the first cycle of a timeout (partial) burst
module fifo_burst_reader #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned BURST_LEN     = 4,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  fifo_burst_reader_if.master bus,
  output logic                o_BUSY,
  output logic                o_FLUSH
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(FLUSH_TIMEOUT) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_flush_start;
  logic [CW-1:0]    w_len_nxt;

  logic [CW-1:0]    r_reads_left;
  logic [TW-1:0]    r_timer;
  logic             r_flush;
  logic             r_inflight;
  logic             r_inflight_last;

  // 3-entry in-order skid buffer
  logic [WIDTH-1:0] r_buf_data [0:2];
  logic             r_buf_last [0:2];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_occ;

  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_timeout;
  logic             w_tvalid;
  logic             w_head_last;
  logic             w_xfer;
  logic             w_rd_en;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_count     = bus.i_FIFO_COUNT;
  assign w_full      = (w_count >= CW'(BURST_LEN));
  assign w_timeout   = (w_count != '0) && (r_timer == TW'(FLUSH_TIMEOUT - 1));
  assign w_tvalid    = (r_occ != 2'd0);
  assign w_head_last = w_tvalid & r_buf_last[r_rd_ptr];
  assign w_xfer      = w_tvalid & bus.i_TREADY;

  // Read only while the buffer plus the word in flight leave room; registers only, no TREADY path
  assign w_rd_en = (r_state == BURST) && (r_reads_left != '0) &&
                   ((3'(r_occ) + 3'(r_inflight)) <= 3'd2);

  assign bus.o_FIFO_RD_EN = w_rd_en;
  assign bus.o_TDATA      = r_buf_data[r_rd_ptr];
  assign bus.o_TVALID     = w_tvalid;
  assign bus.o_TLAST      = w_head_last;
  assign o_BUSY           = (r_state == BURST);
  assign o_FLUSH          = r_flush;

  // Next-state: full burst has priority over a timeout flush
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_flush_start = 1'b0;
    w_len_nxt     = r_reads_left;
    case (r_state)
      IDLE: begin
        if (w_full) begin
          w_state_nxt = BURST;
          w_start     = 1'b1;
          w_len_nxt   = CW'(BURST_LEN);
        end else if (w_timeout) begin
          w_state_nxt   = BURST;
          w_start       = 1'b1;
          w_flush_start = 1'b1;
          w_len_nxt     = w_count;
        end
      end
      BURST: begin
        if (w_xfer && w_head_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, timer, read counter and skid buffer
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state         <= IDLE;
      r_flush         <= 1'b0;
      r_reads_left    <= '0;
      r_timer         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= 2'd0;
      r_rd_ptr        <= 2'd0;
      r_occ           <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_flush_start;

      if (w_start)      r_reads_left <= w_len_nxt;
      else if (w_rd_en) r_reads_left <= r_reads_left - CW'(1);

      if ((r_state != IDLE) || w_start || (w_count == '0)) r_timer <= '0;
      else                                                  r_timer <= r_timer + TW'(1);

      // Last read of the burst carries the TLAST marker into the buffer
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && (r_reads_left == CW'(1));

      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= bus.i_FIFO_DATA;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      if (w_xfer) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ <= r_occ + 2'(r_inflight) - 2'(w_xfer);
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned BL    = 4;
  localparam int unsigned FT    = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  logic busy;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  fifo_burst_reader_if #(.WIDTH(WIDTH), .CW(CW)) bus_if ();

  fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BL), .FLUSH_TIMEOUT(FT)) dut (
    .i_CLK  (clk),
    .i_RESET(rst),
    .bus    (bus_if),
    .o_BUSY (busy),
    .o_FLUSH(flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: 1-cycle read latency; scoreboard entry pushed when a word is written
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             wr_en   = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  initial begin
    bus_if.i_FIFO_COUNT = '0;
    bus_if.i_FIFO_DATA  = '0;
  end

  always @(posedge clk) begin
    if (bus_if.o_FIFO_RD_EN) begin
      chk(fq.size() != 0, "underflow", fq.size(), 1);
      if (fq.size() != 0) bus_if.i_FIFO_DATA <= fq.pop_front();
    end
    if (wr_en) begin
      chk(fq.size() < DEPTH, "overflow", fq.size(), DEPTH - 1);
      fq.push_back(wr_data);
      exp_q.push_back(wr_data);
    end
    bus_if.i_FIFO_COUNT <= CW'(fq.size());
  end

  // Ready pattern generator: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready
  int mode  = 0;
  int phase = 0;
  initial begin
    bus_if.i_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       bus_if.i_TREADY = 1'b1;
        1:       bus_if.i_TREADY = (phase % 3 == 0);
        2:       bus_if.i_TREADY = 1'($urandom_range(0, 1));
        default: bus_if.i_TREADY = 1'b0;
      endcase
      phase++;
    end
  end

  // Monitor / reference model: bursts, flush rule, TLAST position, ordering, stall stability
  int          reads_tot = 0, xfers_tot = 0, nz_run = 0;
  int          exp_len = 0, idx = 0, burst_reads = 0;
  bit          have_pred = 0, exp_busy_next = 0;
  bit          prev_busy = 0, prev_reset = 0, prev_stall = 0, prev_last = 0;
  logic [WIDTH-1:0] prev_data = '0;
  int          prev_cnt = 0;

  always @(negedge clk) begin
    bit xfer, rising, start;
    int cnt;
    logic [WIDTH-1:0] e;
    xfer   = bus_if.o_TVALID & bus_if.i_TREADY;
    cnt    = int'(bus_if.i_FIFO_COUNT);
    rising = busy && !prev_busy;

    if (prev_reset) begin
      chk({bus_if.o_TVALID, bus_if.o_TLAST, bus_if.o_FIFO_RD_EN, busy, flush} == 5'b0 &&
          bus_if.o_TDATA == '0, "reset_outputs",
          {bus_if.o_TDATA, bus_if.o_TVALID, bus_if.o_TLAST, bus_if.o_FIFO_RD_EN, busy, flush}, 0);
    end else begin
      if (have_pred) chk(busy == exp_busy_next, "busy", busy, exp_busy_next);
      if (prev_stall)
        chk(bus_if.o_TVALID && bus_if.o_TDATA == prev_data && bus_if.o_TLAST == prev_last,
            "stall_hold", {bus_if.o_TVALID, bus_if.o_TLAST, bus_if.o_TDATA},
            {1'b1, prev_last, prev_data});
      if (rising) begin
        exp_len     = (prev_cnt >= int'(BL)) ? int'(BL) : prev_cnt;
        idx         = 0;
        burst_reads = 0;
      end
      chk(flush == (rising && exp_len < int'(BL)), "flush", flush, rising && exp_len < int'(BL));
    end

    if (bus_if.o_FIFO_RD_EN) begin
      reads_tot++;
      burst_reads++;
    end

    if (xfer) begin
      xfers_tot++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "extra_word", bus_if.o_TDATA, 0);
      end else begin
        e = exp_q.pop_front();
        chk(bus_if.o_TDATA == e, "data", bus_if.o_TDATA, e);
      end
      chk(bus_if.o_TLAST == (idx == exp_len - 1), "tlast", bus_if.o_TLAST, idx == exp_len - 1);
      if (bus_if.o_TLAST) chk(burst_reads == exp_len, "burst_reads", burst_reads, exp_len);
      idx++;
    end

    chk(reads_tot - xfers_tot <= 3, "outstanding", reads_tot - xfers_tot, 3);

    if (rst) begin
      // Words already read from the FIFO but not delivered are lost by the reset
      for (int k = 0; k < reads_tot - xfers_tot; k++)
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      reads_tot = xfers_tot;
      nz_run    = 0;
      have_pred = 0;
    end else begin
      if (busy) begin
        exp_busy_next = !(xfer && bus_if.o_TLAST);
        nz_run        = 0;
      end else begin
        start         = (cnt >= int'(BL)) || (cnt > 0 && nz_run == int'(FT) - 1);
        exp_busy_next = start;
        nz_run        = (start || cnt == 0) ? 0 : nz_run + 1;
      end
      have_pred = 1;
    end

    prev_stall = bus_if.o_TVALID && !bus_if.i_TREADY && !rst;
    prev_data  = bus_if.o_TDATA;
    prev_last  = bus_if.o_TLAST;
    prev_busy  = busy;
    prev_reset = rst;
    prev_cnt   = cnt;
  end

  task automatic write_seq(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_data = base + WIDTH'(i);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(n < 600, name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Two full bursts with a ready consumer
    mode = 0;
    write_seq(8'h10, 8);
    drain("drain_two_bursts");

    // Partial burst forced by the idle timeout
    write_seq(8'hA0, 2);
    drain("drain_flush");

    // Backpressure pattern 1,0,0
    mode = 1;
    write_seq(8'h10, 8);
    drain("drain_backpressure");

    // Consumer stalled completely: buffer fills, reads must stop
    mode = 3;
    write_seq(8'h30, 6);
    repeat (20) @(negedge clk);
    mode = 0;
    drain("drain_stalled");

    // Reset in the middle of a burst after its second word
    mode = 0;
    fork
      write_seq(8'h10, 8);
      begin
        n = 0;
        while (!(busy && idx == 2) && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk(n < 200, "reset_wait", n, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    drain("drain_after_reset");

    // Random writes and random ready
    mode = 2;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      wr_en   = ($urandom_range(0, 1) == 1) && (fq.size() < DEPTH - 1);
      wr_data = WIDTH'($urandom);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mode  = 0;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
